// File: rtl/conv_pkg.sv
// Shared types for the convolution/pooling datapath: widths, pool FSM states
// and a signed max helper.
package conv_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int DIM_W      = 9;

  typedef enum logic [1:0] {
    POOL_IDLE     = 2'd0,
    POOL_EVEN_ROW = 2'd1,
    POOL_ODD_ROW  = 2'd2,
    POOL_SKIP_ROW = 2'd3
  } pool_state_e;

  function automatic logic signed [DATA_WIDTH-1:0] smax(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Line buffer holding one row of horizontal pair-maxima; synchronous write,
// asynchronous read, both addressed by the pair index (col_cnt >> 1).
module pool_line_buf
  import conv_pkg::*;
#(
  parameter int DataWidth = DATA_WIDTH,
  parameter int Depth     = 256,
  parameter int AddrW     = 8
) (
  input  logic                        clk_i,
  input  logic                        we_i,
  input  logic        [AddrW-1:0]     addr_i,
  input  logic signed [DataWidth-1:0] wdata_i,
  output logic signed [DataWidth-1:0] rdata_o
);

  // Contents are meaningless until written by an even row, so no reset.
  logic signed [DataWidth-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/max_pool.sv
// 2x2 stride-2 signed max pooling over a row-major pixel stream.
// Build option MAX_POOL_RELU_EN clamps negative pooled results to zero.
module max_pool
  import conv_pkg::*;
#(
  parameter int DataWidth = DATA_WIDTH,
  parameter int MaxCols   = 256
) (
  input  logic                        Clk,
  input  logic                        Rst,
  input  logic        [DIM_W-1:0]     row_in,
  input  logic        [DIM_W-1:0]     col_in,
  input  logic signed [DataWidth-1:0] data_in,
  input  logic                        data_valid,
  output logic signed [DataWidth-1:0] result_out,
  output logic                        result_ready,
  output logic                        frame_done,
  output pool_state_e                 dbg_state
);

  localparam int AddrW = (MaxCols > 1) ? $clog2(MaxCols) : 1;

  // Handshake: data_valid qualifies one pixel per cycle with no backpressure;
  // result_ready and frame_done are single-cycle strobes with no acknowledge.
  pool_state_e                 state_q, state_d;
  logic        [DIM_W-1:0]     rows_q, rows_d, cols_q, cols_d;
  logic        [DIM_W-1:0]     row_cnt_q, row_cnt_d, col_cnt_q, col_cnt_d;
  logic signed [DataWidth-1:0] pair_q, pair_d, result_q, result_d;
  logic                        ready_q, ready_d, done_q, done_d;

  logic                        idle;
  pool_state_e                 cur_state;
  logic        [DIM_W-1:0]     rows_eff, cols_eff, row_last, col_last, next_row;
  logic                        last_col, last_row, col_odd, in_range;
  logic                        buf_we;
  logic        [AddrW-1:0]     buf_addr;
  logic signed [DataWidth-1:0] buf_wdata, buf_rdata;
  logic signed [DATA_WIDTH-1:0] px_w, pair_w, bufr_w, pair_max_w, pool_w;

  always_comb begin
    idle      = (state_q == POOL_IDLE);
    // The beat that starts a frame is processed as pixel (0,0) of an even row.
    cur_state = idle ? POOL_EVEN_ROW : state_q;
    rows_eff  = idle ? row_in : rows_q;
    cols_eff  = idle ? col_in : cols_q;
    row_last  = (rows_eff == '0) ? '0 : rows_eff - DIM_W'(1);
    col_last  = (cols_eff == '0) ? '0 : cols_eff - DIM_W'(1);
    last_col  = (col_cnt_q == col_last);
    last_row  = (row_cnt_q == row_last);
    next_row  = row_cnt_q + DIM_W'(1);
    col_odd   = col_cnt_q[0];
    in_range  = int'(col_cnt_q >> 1) < MaxCols;
    buf_addr  = AddrW'(col_cnt_q >> 1);

    px_w       = DATA_WIDTH'(data_in);
    pair_w     = DATA_WIDTH'(pair_q);
    bufr_w     = DATA_WIDTH'(buf_rdata);
    pair_max_w = smax(pair_w, px_w);
    pool_w     = smax(bufr_w, pair_max_w);

    buf_we    = data_valid && (cur_state == POOL_EVEN_ROW) && col_odd && in_range;
    buf_wdata = DataWidth'(pair_max_w);
  end

  always_comb begin
    state_d   = state_q;
    rows_d    = rows_q;
    cols_d    = cols_q;
    row_cnt_d = row_cnt_q;
    col_cnt_d = col_cnt_q;
    pair_d    = pair_q;
    result_d  = result_q;
    ready_d   = 1'b0;
    done_d    = 1'b0;

    if (data_valid) begin
      if (idle) begin
        rows_d = row_in;
        cols_d = col_in;
      end
      if (!col_odd) begin
        pair_d = data_in;
      end
      if ((cur_state == POOL_ODD_ROW) && col_odd && in_range) begin
        ready_d = 1'b1;
`ifdef MAX_POOL_RELU_EN
        result_d = pool_w[DATA_WIDTH-1] ? '0 : DataWidth'(pool_w);
`else
        result_d = DataWidth'(pool_w);
`endif
      end

      if (last_col && last_row) begin
        state_d   = POOL_IDLE;
        row_cnt_d = '0;
        col_cnt_d = '0;
        done_d    = 1'b1;
      end else if (last_col) begin
        col_cnt_d = '0;
        row_cnt_d = next_row;
        // An even row with no partner below it is consumed without output.
        if (next_row[0]) begin
          state_d = POOL_ODD_ROW;
        end else if (next_row == row_last) begin
          state_d = POOL_SKIP_ROW;
        end else begin
          state_d = POOL_EVEN_ROW;
        end
      end else begin
        col_cnt_d = col_cnt_q + DIM_W'(1);
        state_d   = cur_state;
      end
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q   <= POOL_IDLE;
      rows_q    <= '0;
      cols_q    <= '0;
      row_cnt_q <= '0;
      col_cnt_q <= '0;
      pair_q    <= '0;
      result_q  <= '0;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rows_q    <= rows_d;
      cols_q    <= cols_d;
      row_cnt_q <= row_cnt_d;
      col_cnt_q <= col_cnt_d;
      pair_q    <= pair_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
    end
  end

  pool_line_buf #(
    .DataWidth (DataWidth),
    .Depth     (MaxCols),
    .AddrW     (AddrW)
  ) u_line_buf (
    .clk_i   (Clk),
    .we_i    (buf_we),
    .addr_i  (buf_addr),
    .wdata_i (buf_wdata),
    .rdata_o (buf_rdata)
  );

  assign result_out   = result_q;
  assign result_ready = ready_q;
  assign frame_done   = done_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_max_pool.sv
// Randomised scoreboard bench for max_pool: a frame-level reference computes
// each pooled window directly from the pixel array.
`timescale 1ns/1ps
module tb_max_pool;
  import conv_pkg::*;

  localparam int DW = 64;

  logic                 Clk = 1'b0;
  logic                 Rst;
  logic        [8:0]    row_in, col_in;
  logic signed [DW-1:0] data_in;
  logic                 data_valid;
  logic signed [DW-1:0] result_out;
  logic                 result_ready, frame_done;
  pool_state_e          dbg_state;

  max_pool #(.DataWidth(DW), .MaxCols(256)) dut (
    .Clk          (Clk),
    .Rst          (Rst),
    .row_in       (row_in),
    .col_in       (col_in),
    .data_in      (data_in),
    .data_valid   (data_valid),
    .result_out   (result_out),
    .result_ready (result_ready),
    .frame_done   (frame_done),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [DW-1:0]        exp_q[$];
  int                   exp_cyc_q[$];
  int                   done_cyc_q[$];
  logic [DW-1:0]        last_exp = '0;
  logic signed [DW-1:0] pix [0:1023];

  // ---------------- monitor ----------------
  logic [DW-1:0] mon_v;
  int            mon_c;

  always @(posedge Clk) begin
    #1;
    if (Rst) begin
      last_exp = '0;
      checks++;
      if (result_ready !== 1'b0 || frame_done !== 1'b0 || result_out !== '0) begin
        errors++;
        $display("FAIL reset_outputs: ready=%0b done=%0b out=%0d, required 0 0 0",
                 result_ready, frame_done, result_out);
      end
    end else begin
      if (result_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: out=%0d at cycle %0d, required no result_ready",
                   result_out, cyc);
        end else begin
          mon_v = exp_q.pop_front();
          mon_c = exp_cyc_q.pop_front();
          last_exp = mon_v;
          if (result_out !== mon_v || cyc != mon_c) begin
            errors++;
            $display("FAIL pooled_result: out=%0d at cycle %0d, required %0d at cycle %0d",
                     result_out, cyc, $signed(mon_v), mon_c);
          end
        end
      end else begin
        checks++;
        if (result_ready !== 1'b0 || result_out !== last_exp) begin
          errors++;
          $display("FAIL hold_result: ready=%0b out=%0d at cycle %0d, required 0 and %0d",
                   result_ready, result_out, cyc, $signed(last_exp));
        end
      end

      if (frame_done === 1'b1) begin
        checks++;
        if (done_cyc_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_frame_done: at cycle %0d, required no pulse", cyc);
        end else begin
          mon_c = done_cyc_q.pop_front();
          if (cyc != mon_c) begin
            errors++;
            $display("FAIL frame_done_cycle: pulse at cycle %0d, required cycle %0d", cyc, mon_c);
          end
        end
      end else if (frame_done !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL frame_done_level: value %0b at cycle %0d, required 0 or 1", frame_done, cyc);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge Clk);
      data_valid = 1'b0;
      data_in    = {$urandom, $urandom};
      row_in     = 9'($urandom_range(0, 511));
      col_in     = 9'($urandom_range(0, 511));
    end
  endtask

  // Drives the first n_beats pixels of a rows x cols frame from pix[]; the
  // expected pooled value is the max of the 2x2 window ending at an odd/odd pixel.
  task automatic drive_frame(input int rows, input int cols, input int n_beats, input int gap_mode);
    int n;
    int r;
    int c;
    logic signed [DW-1:0] m;
    n = rows * cols;
    for (int i = 0; i < n_beats && i < n; i++) begin
      r = i / cols;
      c = i % cols;
      @(negedge Clk);
      data_valid = 1'b1;
      data_in    = pix[i];
      if (i == 0) begin
        row_in = 9'(rows);
        col_in = 9'(cols);
      end else begin
        row_in = 9'($urandom_range(0, 511));
        col_in = 9'($urandom_range(0, 511));
      end
      if ((r % 2 == 1) && (c % 2 == 1) && (r / 2 < rows / 2) && (c / 2 < cols / 2)) begin
        m = pix[(r-1)*cols + c - 1];
        if (pix[(r-1)*cols + c] > m) m = pix[(r-1)*cols + c];
        if (pix[r*cols + c - 1] > m) m = pix[r*cols + c - 1];
        if (pix[r*cols + c] > m)     m = pix[r*cols + c];
`ifdef MAX_POOL_RELU_EN
        if (m < 0) m = '0;
`endif
        exp_q.push_back(m);
        exp_cyc_q.push_back(cyc + 1);
      end
      if (i == n - 1) done_cyc_q.push_back(cyc + 1);
      if (gap_mode == 1) idle_cycles(1);
      else if (gap_mode == 2) idle_cycles($urandom_range(0, 2));
    end
  endtask

  task automatic fill_ramp(input int n);
    for (int i = 0; i < n; i++) pix[i] = 64'(i + 1);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  int rows_r, cols_r, gap_r;

  initial begin
    Rst        = 1'b1;
    data_valid = 1'b0;
    data_in    = '0;
    row_in     = '0;
    col_in     = '0;
    repeat (3) @(negedge Clk);
    checks++;
    if (dbg_state !== POOL_IDLE) begin
      errors++;
      $display("FAIL reset_state: state=%0d, required %0d", dbg_state, POOL_IDLE);
    end
    Rst = 1'b0;
    idle_cycles(2);

    // 7x7 ramp, continuous valid
    fill_ramp(49);
    drive_frame(7, 7, 49, 0);
    idle_cycles(3);

    // all-negative 4x4
    for (int i = 0; i < 16; i++) pix[i] = 64'(-(i + 1));
    drive_frame(4, 4, 16, 0);
    idle_cycles(2);

    // 4x4 ramp with valid every other cycle
    fill_ramp(16);
    drive_frame(4, 4, 16, 1);
    idle_cycles(2);

    // abort a 7x7 frame after 10 pixels
    fill_ramp(49);
    drive_frame(7, 7, 10, 0);
    @(negedge Clk);
    Rst        = 1'b1;
    data_valid = 1'b0;
    @(negedge Clk);
    checks++;
    if (dbg_state !== POOL_IDLE || exp_q.size() != 0) begin
      errors++;
      $display("FAIL abort_state: state=%0d pending=%0d, required %0d and 0",
               dbg_state, exp_q.size(), POOL_IDLE);
    end
    Rst = 1'b0;
    idle_cycles(2);

    // fresh 2x2 frame after abort
    pix[0] = 64'(5);
    pix[1] = 64'(-2);
    pix[2] = 64'(7);
    pix[3] = 64'(3);
    drive_frame(2, 2, 4, 0);
    idle_cycles(2);

    // degenerate 1x7 followed back-to-back by a 7x7 ramp
    fill_ramp(7);
    drive_frame(1, 7, 7, 0);
    fill_ramp(49);
    drive_frame(7, 7, 49, 0);
    idle_cycles(3);

    // randomised frames
    for (int f = 0; f < 14; f++) begin
      rows_r = $urandom_range(1, 9);
      cols_r = $urandom_range(1, 24);
      gap_r  = $urandom_range(0, 2);
      for (int i = 0; i < rows_r * cols_r; i++) begin
        if (f % 2 == 0) pix[i] = 64'($signed($urandom_range(0, 16)) - 8);
        else            pix[i] = {$urandom, $urandom};
      end
      drive_frame(rows_r, cols_r, rows_r * cols_r, gap_r);
      if ($urandom_range(0, 1) == 1) idle_cycles($urandom_range(1, 3));
    end
    idle_cycles(5);

    checks++;
    if (exp_q.size() != 0 || done_cyc_q.size() != 0) begin
      errors++;
      $display("FAIL drain: results pending=%0d frame_done pending=%0d, required 0 and 0",
               exp_q.size(), done_cyc_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
